// File: rtl/array_pkg.sv
// ---------------------------------------------------------------------------
// array_pkg
// Shared constants for the 4x4 output-stationary systolic MAC array and its
// sequencer: operand/accumulator widths, array dimension, feed length and the
// sequencer state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package array_pkg;

    localparam int DATA_WIDTH  = 8;
    localparam int ACC_WIDTH   = 2 * DATA_WIDTH + 4;
    localparam int N           = 4;
    // Diagonal skew across an NxN array needs 3N-2 cycles to drain the last
    // operand pair into PE[N-1][N-1].
    localparam int FEED_CYCLES = 3 * N - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_FEED  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] T_LAST = 4'(FEED_CYCLES - 1);

endpackage

// File: rtl/array_skew_mux.sv
// ---------------------------------------------------------------------------
// array_skew_mux
// Combinational diagonal-skew selector. For feed step t it picks, for every
// edge lane l, the operand element whose index along the reduction dimension
// is k = t - l (zero when k falls outside 0..N-1 or when en is low).
//   COL_MAJOR = 0 : lane l = tile entry l, byte k   (A rows -> array rows)
//   COL_MAJOR = 1 : lane l = tile entry k, byte l   (B rows -> array columns)
// Ports:
//   en        in   lane outputs forced to zero when low
//   t         in   feed step counter
//   tile      in   N entries of N bytes; entry e at [(e*N)*DATA_WIDTH +: N*DATA_WIDTH]
//   edge_vec  out  N lanes of DATA_WIDTH, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module array_skew_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter bit COL_MAJOR  = 1'b0
) (
    input  logic                         en,
    input  logic [3:0]                   t,
    input  logic [N*N*DATA_WIDTH-1:0]    tile,
    output logic [N*DATA_WIDTH-1:0]      edge_vec
);

    int unsigned tt;
    int unsigned k;

    always_comb begin
        edge_vec = '0;
        tt       = 32'(t);
        k        = 0;
        for (int unsigned l = 0; l < N; l++) begin
            if (en && (tt >= l) && ((tt - l) < N)) begin
                k = tt - l;
                if (COL_MAJOR)
                    edge_vec[l*DATA_WIDTH +: DATA_WIDTH] = tile[(k*N + l)*DATA_WIDTH +: DATA_WIDTH];
                else
                    edge_vec[l*DATA_WIDTH +: DATA_WIDTH] = tile[(l*N + k)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/array_ctrl.sv
// ---------------------------------------------------------------------------
// array_ctrl
// Sequencer for the 4x4 output-stationary systolic MAC array. Holds the A and
// B operand tiles, and on start clears the array accumulators (CLEAR), feeds
// skewed activations/weights for FEED_CYCLES cycles (FEED) and pulses done.
// Optional feature macro: ARRAY_CTRL_ACCUM_EN adds the accumulate input; a
// start with accumulate=1 skips CLEAR so products add onto existing results.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   wr_en        operand buffer write strobe (honoured only while idle)
//   wr_sel       0 = A buffer, 1 = B buffer
//   wr_idx       buffer entry (A row i / B row j)
//   wr_data      entry data, byte k = element k
//   start        begin a tile computation (sampled while idle)
//   accumulate   (ARRAY_CTRL_ACCUM_EN only) skip the accumulator clear
//   busy         high whenever not idle
//   done         one-cycle pulse, array results valid
//   arr_rst_n    array accumulator clear, active-low
//   arr_we       array write enable
//   arr_a_in     row activations, slice y feeds array row y
//   arr_b_in     column weights, slice x feeds array column x
// ---------------------------------------------------------------------------
module array_ctrl #(
    parameter int DATA_WIDTH = array_pkg::DATA_WIDTH,
    parameter int N          = array_pkg::N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [1:0]                 wr_idx,
    input  logic [DATA_WIDTH*N-1:0]    wr_data,
    input  logic                       start,
`ifdef ARRAY_CTRL_ACCUM_EN
    input  logic                       accumulate,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       arr_rst_n,
    output logic                       arr_we,
    output logic [DATA_WIDTH*N-1:0]    arr_a_in,
    output logic [DATA_WIDTH*N-1:0]    arr_b_in
);

    import array_pkg::*;

    logic [1:0]                  state;
    logic [3:0]                  t;
    logic                        rst_q;
    logic [N*N*DATA_WIDTH-1:0]   a_buf;
    logic [N*N*DATA_WIDTH-1:0]   b_buf;
    logic                        skip_clear;

`ifdef ARRAY_CTRL_ACCUM_EN
    assign skip_clear = accumulate;
`else
    assign skip_clear = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            t     <= '0;
            rst_q <= 1'b1;
            a_buf <= '0;
            b_buf <= '0;
        end else begin
            rst_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        if (wr_sel)
                            b_buf[int'(wr_idx)*(N*DATA_WIDTH) +: N*DATA_WIDTH] <= wr_data;
                        else
                            a_buf[int'(wr_idx)*(N*DATA_WIDTH) +: N*DATA_WIDTH] <= wr_data;
                    end
                    t <= '0;
                    if (start)
                        state <= skip_clear ? ST_FEED : ST_CLEAR;
                end
                ST_CLEAR: begin
                    t     <= '0;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (t == T_LAST) begin
                        t     <= '0;
                        state <= ST_DONE;
                    end else begin
                        t <= t + 4'd1;
                    end
                end
                default: begin
                    t     <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // rst_q keeps the array clear asserted for the cycle after a reset edge,
    // so outputs stay decoded from registers only.
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign arr_we    = (state == ST_FEED);
    assign arr_rst_n = ~(rst_q | (state == ST_CLEAR));

    array_skew_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .COL_MAJOR  (1'b0)
    ) u_skew_a (
        .en       (arr_we),
        .t        (t),
        .tile     (a_buf),
        .edge_vec (arr_a_in)
    );

    array_skew_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .N          (N),
        .COL_MAJOR  (1'b1)
    ) u_skew_b (
        .en       (arr_we),
        .t        (t),
        .tile     (b_buf),
        .edge_vec (arr_b_in)
    );

endmodule

// File: tb/tb_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_array_ctrl
// Bench for array_ctrl with a small behavioural systolic array attached to the
// controller outputs so end results (c = A x B) can be checked.
// ---------------------------------------------------------------------------
module tb_array_ctrl;

    localparam int DW = 8;
    localparam int N  = 4;
`ifdef ARRAY_CTRL_ACCUM_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic              wr_sel = 1'b0;
    logic [1:0]        wr_idx = 2'd0;
    logic [DW*N-1:0]   wr_data = '0;
    logic              start = 1'b0;
    logic              accumulate = 1'b0;
    logic              busy, done, arr_rst_n, arr_we;
    logic [DW*N-1:0]   arr_a_in, arr_b_in;

    always #5 clk = ~clk;

    array_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .start      (start),
`ifdef ARRAY_CTRL_ACCUM_EN
        .accumulate (accumulate),
`endif
        .busy       (busy),
        .done       (done),
        .arr_rst_n  (arr_rst_n),
        .arr_we     (arr_we),
        .arr_a_in   (arr_a_in),
        .arr_b_in   (arr_b_in)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: timeline since accepted start -------
    // m_cyc: 0 idle, 1 clear, 2..11 feed (t = m_cyc-2), 12 done.
    int ma[N][N];
    int mb[N][N];
    int m_cyc = 0;
    bit m_rstq = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc  = 0;
            m_rstq = 1'b1;
            chk_en = 1'b1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = 0;
                    mb[i][j] = 0;
                end
        end else begin
            m_rstq = 1'b0;
            if (m_cyc == 0) begin
                if (wr_en)
                    for (int k = 0; k < N; k++) begin
                        if (wr_sel) mb[wr_idx][k] = int'(wr_data[8*k +: 8]);
                        else        ma[wr_idx][k] = int'(wr_data[8*k +: 8]);
                    end
                if (start) m_cyc = (ACC_ON && accumulate) ? 2 : 1;
            end else begin
                m_cyc = (m_cyc == 12) ? 0 : m_cyc + 1;
            end
        end
    end

    function automatic logic [DW*N-1:0] exp_a(input int t);
        logic [DW*N-1:0] r;
        r = '0;
        for (int y = 0; y < N; y++)
            if (t - y >= 0 && t - y <= N - 1) r[8*y +: 8] = 8'(ma[y][t-y]);
        return r;
    endfunction

    function automatic logic [DW*N-1:0] exp_b(input int t);
        logic [DW*N-1:0] r;
        r = '0;
        for (int x = 0; x < N; x++)
            if (t - x >= 0 && t - x <= N - 1) r[8*x +: 8] = 8'(mb[t-x][x]);
        return r;
    endfunction

    // ---------------- per-cycle compare ------------------------------------
    int  cmp_t;
    bit  cmp_feed;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_t    = m_cyc - 2;
            cmp_feed = (m_cyc >= 2) && (m_cyc <= 11);
            chk("busy",      64'(busy),      64'(m_cyc != 0));
            chk("done",      64'(done),      64'(m_cyc == 12));
            chk("arr_we",    64'(arr_we),    64'(cmp_feed));
            chk("arr_rst_n", 64'(arr_rst_n), 64'(!(m_rstq || m_cyc == 1)));
            chk("arr_a_in",  64'(arr_a_in),  64'(cmp_feed ? exp_a(cmp_t) : '0));
            chk("arr_b_in",  64'(arr_b_in),  64'(cmp_feed ? exp_b(cmp_t) : '0));
        end
        if (done === 1'b1) n_done++;
    end

    // ---------------- behavioural systolic array ---------------------------
    int ar[N][N];
    int br[N][N];
    int c[N][N];
    int ain, bin;
    always @(posedge clk) begin
        if (arr_rst_n === 1'b0) begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++) begin
                    ar[y][x] <= 0;
                    br[y][x] <= 0;
                    c[y][x]  <= 0;
                end
        end else if (arr_we === 1'b1) begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++) begin
                    if (x == 0) ain = int'(arr_a_in[8*y +: 8]);
                    else        ain = ar[y][x-1];
                    if (y == 0) bin = int'(arr_b_in[8*x +: 8]);
                    else        bin = br[y-1][x];
                    ar[y][x] <= ain;
                    br[y][x] <= bin;
                    c[y][x]  <= c[y][x] + ain * bin;
                end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load(input bit sel, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3);
        logic [31:0] rows[4];
        rows = '{r0, r1, r2, r3};
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_idx  = 2'(i);
            wr_data = rows[i];
            step(1);
        end
        wr_en = 1'b0;
    endtask

    // Issues start (plus whatever wr_* is already set up), waits for done
    // with a bound and checks the start-to-done latency.
    task automatic run(input bit acc, input int exp_lat, input string tag);
        int lat;
        start      = 1'b1;
        accumulate = acc;
        @(posedge clk);
        #2;
        start      = 1'b0;
        accumulate = 1'b0;
        wr_en      = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic chk_mat(input string tag);
        int e;
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) begin
                e = 0;
                for (int k = 0; k < N; k++) e += ma[y][k] * mb[k][x];
                chk($sformatf("%s_c%0d%0d", tag, y, x), 64'(c[y][x]), 64'(e));
            end
    endtask

    // ---------------- directed sequence ------------------------------------
    int d0;
    initial begin
        step(2);
        @(negedge clk);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_arr_rst_n", 64'(arr_rst_n), 64'd0);
        chk("rst_arr_we",    64'(arr_we),    64'd0);
        chk("rst_a_in",      64'(arr_a_in),  64'd0);
        rst = 1'b0;
        step(1);

        // identity A, B = 1..16 -> c = B
        load(1'b0, 32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
        load(1'b1, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
        run(1'b0, 12, "ident");
        chk("ident_c21_lit", 64'(c[2][1]), 64'd10);
        chk("ident_c33_lit", 64'(c[3][3]), 64'd16);
        chk_mat("ident");

        // A all 1, B all 2 -> c = 8; spot-check the edge feed
        step(1);
        load(1'b0, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        load(1'b1, 32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        @(negedge clk);
        chk("clear_rst_n_lit", 64'(arr_rst_n), 64'd0);
        @(negedge clk);
        chk("t0_a_lit", 64'(arr_a_in), 64'h00000001);
        chk("t0_b_lit", 64'(arr_b_in), 64'h00000002);
        repeat (6) @(negedge clk);
        chk("t6_a_lit", 64'(arr_a_in), 64'h01000000);
        chk("t6_b_lit", 64'(arr_b_in), 64'h02000000);
        repeat (3) @(negedge clk);
        chk("t9_a_lit", 64'(arr_a_in), 64'h0);
        chk("t9_we_lit", 64'(arr_we), 64'd1);
        @(negedge clk);
        chk("ones2_done_lit", 64'(done), 64'd1);
        chk("ones2_c00_lit", 64'(c[0][0]), 64'd8);
        chk_mat("ones2");

        // start and writes during FEED are ignored
        step(1);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        d0 = n_done;
        step(5);
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_idx  = 2'd1;
        wr_data = 32'hFFFFFFFF;
        step(1);
        start = 1'b0;
        wr_en = 1'b0;
        step(30);
        chk("busy_single_done", 64'(n_done - d0), 64'd1);
        run(1'b0, 12, "rerun");
        chk("rerun_c12_lit", 64'(c[1][2]), 64'd8);
        chk_mat("rerun");

        // reset at FEED t=5 aborts the run
        step(1);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy_lit",  64'(busy),      64'd0);
        chk("abort_rst_n_lit", 64'(arr_rst_n), 64'd0);
        d0 = n_done;
        step(20);
        chk("abort_no_done", 64'(n_done - d0), 64'd0);
        chk("abort_c00_lit", 64'(c[0][0]), 64'd0);
        load(1'b0, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        load(1'b1, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        run(1'b0, 12, "ones");
        chk("ones_c11_lit", 64'(c[1][1]), 64'd4);
        chk_mat("ones");

        // A write in the same cycle as start is used by the feed
        step(1);
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_idx  = 2'd0;
        wr_data = 32'h04030201;
        run(1'b0, 12, "wrstart");
        chk("wrstart_c00_lit", 64'(c[0][0]), 64'd10);
        chk("wrstart_c10_lit", 64'(c[1][0]), 64'd4);
        chk_mat("wrstart");

`ifdef ARRAY_CTRL_ACCUM_EN
        step(1);
        load(1'b0, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
        run(1'b0, 12, "acc_base");
        chk("acc_base_c22_lit", 64'(c[2][2]), 64'd4);
        step(1);
        run(1'b1, 11, "acc");
        chk("acc_c22_lit", 64'(c[2][2]), 64'd8);
        chk("acc_c00_lit", 64'(c[0][0]), 64'd8);
`endif

        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
